// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the memory-side arbiter.
// The cache and memory blocks use the same widths.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    typedef enum logic {
        IC = 1'b0,
        DC = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant selection between icache and dcache.
// Ties are broken round-robin or in favour of the dcache.
module rr_arbiter2
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DCACHE_PRIORITY = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic req_ic,
    input  logic req_dc,
    input  logic grant_en,
    output logic winner_dc_c
);

    owner_t last_grant_q;

    // On a tie the requester that was not granted last wins, unless dcache has priority.
    always_comb begin
        winner_dc_c = 1'b0;
        if (req_dc && !req_ic) begin
            winner_dc_c = 1'b1;
        end else if (req_dc && req_ic) begin
            winner_dc_c = (DCACHE_PRIORITY != 0) ? 1'b1 : (last_grant_q == IC);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= IC;
        end else if (grant_en) begin
            last_grant_q <= winner_dc_c ? DC : IC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache and dcache block transfers onto the single data memory.
// Each grant runs IDLE -> BUSY (>=2 cycles) -> RELEASE (1 cycle) -> IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W          = ADDR_W_DEF,
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned DCACHE_PRIORITY = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_address,
    output logic [DATA_W-1:0] ic_readdata,
    output logic              ic_busywait,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_address,
    input  logic [DATA_W-1:0] dc_writedata,
    output logic [DATA_W-1:0] dc_readdata,
    output logic              dc_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              first_q, first_d;
    logic              mem_read_d, mem_write_d;
    logic [ADDR_W-1:0] mem_address_d;
    logic [DATA_W-1:0] mem_writedata_d;
    logic [DATA_W-1:0] ic_readdata_d, dc_readdata_d;

    logic req_ic, req_dc, grant_en, winner_dc_c;

    assign req_ic   = ic_read;
    assign req_dc   = dc_read | dc_write;
    assign grant_en = (state_q == IDLE) && (req_ic || req_dc);

    rr_arbiter2 #(
        .DCACHE_PRIORITY(DCACHE_PRIORITY)
    ) u_rr_arbiter2 (
        .clock      (clock),
        .reset      (reset),
        .req_ic     (req_ic),
        .req_dc     (req_dc),
        .grant_en   (grant_en),
        .winner_dc_c(winner_dc_c)
    );

    // Only the owner is released; the other requester stays stalled.
    assign ic_busywait = req_ic & ~((state_q == RELEASE) && (owner_q == IC));
    assign dc_busywait = req_dc & ~((state_q == RELEASE) && (owner_q == DC));

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        first_d         = first_q;
        mem_read_d      = mem_read;
        mem_write_d     = mem_write;
        mem_address_d   = mem_address;
        mem_writedata_d = mem_writedata;
        ic_readdata_d   = ic_readdata;
        dc_readdata_d   = dc_readdata;
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    state_d = BUSY;
                    first_d = 1'b1;
                    if (winner_dc_c) begin
                        owner_d       = DC;
                        mem_address_d = dc_address;
                        // A simultaneous read and write is taken as a writeback.
                        if (dc_write) begin
                            mem_write_d     = 1'b1;
                            mem_writedata_d = dc_writedata;
                        end else begin
                            mem_read_d = 1'b1;
                        end
                    end else begin
                        owner_d       = IC;
                        mem_address_d = ic_address;
                        mem_read_d    = 1'b1;
                    end
                end
            end
            BUSY: begin
                first_d = 1'b0;
                // Memory raises busywait from the strobe, so the first BUSY edge is skipped.
                if (!first_q && !mem_busywait) begin
                    state_d     = RELEASE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read) begin
                        if (owner_q == DC) begin
                            dc_readdata_d = mem_readdata;
                        end else begin
                            ic_readdata_d = mem_readdata;
                        end
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= IC;
            first_q       <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            ic_readdata   <= '0;
            dc_readdata   <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            first_q       <= first_d;
            mem_read      <= mem_read_d;
            mem_write     <= mem_write_d;
            mem_address   <= mem_address_d;
            mem_writedata <= mem_writedata_d;
            ic_readdata   <= ic_readdata_d;
            dc_readdata   <= dc_readdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, reactive memory,
// directed scenarios and a randomized requester phase.
module tb_mem_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // round-robin instance
    logic          ic_read = 1'b0, dc_read = 1'b0, dc_write = 1'b0;
    logic [AW-1:0] ic_address = '0, dc_address = '0;
    logic [DW-1:0] dc_writedata = '0;
    logic [DW-1:0] ic_readdata, dc_readdata, mem_writedata, mem_readdata;
    logic          ic_busywait, dc_busywait, mem_read, mem_write, mem_busywait;
    logic [AW-1:0] mem_address;

    // dcache-priority instance with a zero-wait memory
    logic          p_ic_read = 1'b0, p_dc_read = 1'b0;
    logic [AW-1:0] p_ic_address = '0, p_dc_address = '0;
    logic [DW-1:0] p_ic_readdata, p_dc_readdata, p_mem_writedata, p_mem_readdata;
    logic          p_ic_busywait, p_dc_busywait, p_mem_read, p_mem_write;
    logic [AW-1:0] p_mem_address;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DCACHE_PRIORITY(0)) dut (
        .clock(clock), .reset(reset),
        .ic_read(ic_read), .ic_address(ic_address), .ic_readdata(ic_readdata), .ic_busywait(ic_busywait),
        .dc_read(dc_read), .dc_write(dc_write), .dc_address(dc_address), .dc_writedata(dc_writedata),
        .dc_readdata(dc_readdata), .dc_busywait(dc_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DCACHE_PRIORITY(1)) dut_p (
        .clock(clock), .reset(reset),
        .ic_read(p_ic_read), .ic_address(p_ic_address), .ic_readdata(p_ic_readdata), .ic_busywait(p_ic_busywait),
        .dc_read(p_dc_read), .dc_write(1'b0), .dc_address(p_dc_address), .dc_writedata('0),
        .dc_readdata(p_dc_readdata), .dc_busywait(p_dc_busywait),
        .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_address(p_mem_address), .mem_writedata(p_mem_writedata),
        .mem_readdata(p_mem_readdata), .mem_busywait(1'b0)
    );

    function automatic logic [DW-1:0] p_pattern(input logic [AW-1:0] a);
        return 32'h5A5A_0000 ^ 32'(a);
    endfunction
    assign p_mem_readdata = p_pattern(p_mem_address);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // memory: busy for mem_n cycles starting with the first strobe cycle
    logic [DW-1:0] mem_array [64];
    int mem_age   = 0;
    int mem_n     = 0;
    int lat_fixed = -1;
    assign mem_busywait = (mem_read || mem_write) && (mem_age < mem_n);
    assign mem_readdata = mem_array[mem_address];

    always @(posedge clock) begin
        if (mem_read || mem_write) begin
            mem_age <= mem_age + 1;
        end else begin
            mem_age <= 0;
            mem_n   <= (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
        end
        if (mem_write) mem_array[mem_address] <= mem_writedata;
    end

    // reference model: one transaction at a time, described by who owns it and how old it is
    bit            m_active = 0, m_release = 0, m_owner_dc = 0, m_wr = 0, m_last_dc = 0;
    int            m_age = 0;
    logic          exp_rd = 0, exp_wr = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0, exp_ic_rd = '0, exp_dc_rd = '0;

    always @(posedge clock) begin
        bit win_dc;
        if (reset) begin
            m_active = 0; m_release = 0; m_last_dc = 0;
            exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wdata = '0;
            exp_ic_rd = '0; exp_dc_rd = '0;
        end else if (m_release) begin
            m_release = 0;
        end else if (m_active) begin
            if (m_age >= 1 && !mem_busywait) begin
                if (!m_wr) begin
                    if (m_owner_dc) exp_dc_rd = mem_array[exp_addr];
                    else            exp_ic_rd = mem_array[exp_addr];
                end
                m_active = 0; m_release = 1; exp_rd = 0; exp_wr = 0;
            end else begin
                m_age++;
            end
        end else if (ic_read || dc_read || dc_write) begin
            if (ic_read && (dc_read || dc_write)) win_dc = !m_last_dc;
            else                                  win_dc = !ic_read;
            m_last_dc  = win_dc;
            m_owner_dc = win_dc;
            m_active   = 1;
            m_age      = 0;
            m_wr       = win_dc && dc_write;
            exp_wr     = m_wr;
            exp_rd     = !m_wr;
            exp_addr   = win_dc ? dc_address : ic_address;
            if (m_wr) exp_wdata = dc_writedata;
        end
    end

    // per-cycle comparison plus a grant monitor
    logic [AW-1:0] grant_q[$];
    bit            prev_strobe = 0;
    int            strobe_len = 0, last_strobe_len = 0;

    always @(negedge clock) begin
        check("mem_read",      32'(mem_read),    32'(exp_rd));
        check("mem_write",     32'(mem_write),   32'(exp_wr));
        check("mem_address",   32'(mem_address), 32'(exp_addr));
        check("mem_writedata", mem_writedata,    exp_wdata);
        check("ic_readdata",   ic_readdata,      exp_ic_rd);
        check("dc_readdata",   dc_readdata,      exp_dc_rd);
        check("ic_busywait",   32'(ic_busywait), 32'(ic_read && !(m_release && !m_owner_dc)));
        check("dc_busywait",   32'(dc_busywait), 32'((dc_read || dc_write) && !(m_release && m_owner_dc)));
        if ((mem_read || mem_write) && !prev_strobe) grant_q.push_back(mem_address);
        if (mem_read || mem_write) strobe_len++;
        else if (prev_strobe) begin last_strobe_len = strobe_len; strobe_len = 0; end
        prev_strobe = mem_read || mem_write;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ic_read = 0; dc_read = 0; dc_write = 0; p_ic_read = 0; p_dc_read = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // sel: 0 ic, 1 dc, 2 priority-ic, 3 priority-dc
    task automatic wait_low(input int sel, input string nm);
        logic bw;
        for (int i = 0; i < 80; i++) begin
            tick();
            case (sel)
                0: bw = ic_busywait;
                1: bw = dc_busywait;
                2: bw = p_ic_busywait;
                default: bw = p_dc_busywait;
            endcase
            if (!bw) return;
        end
        check({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        logic [AW-1:0] a;
        for (int i = 0; i < 64; i++) mem_array[i] <= $urandom;
        mem_array[6'h05] <= 32'hDEADBEEF;
        mem_array[6'h0A] <= 32'hCAFE0A0A;

        // reset values
        do_reset();
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_ic_readdata", ic_readdata, 32'd0);
        check("rst_dc_readdata", dc_readdata, 32'd0);

        // reset during the third busy cycle of a dcache read
        lat_fixed = 6;
        dc_read = 1; dc_address = 6'h0C;
        tick(); tick(); tick();
        check("rb_strobe_before", 32'(mem_read), 32'd1);
        reset = 1'b1;
        tick();
        check("rb_mem_read", 32'(mem_read), 32'd0);
        check("rb_dc_readdata", dc_readdata, 32'd0);
        check("rb_dc_busywait", 32'(dc_busywait), 32'd1);
        check("rb_ic_busywait", 32'(ic_busywait), 32'd0);
        reset = 1'b0; dc_read = 0;
        tick();

        // single icache read, 5 busy cycles
        lat_fixed = 5;
        ic_read = 1; ic_address = 6'h05;
        tick();
        check("ic1_mem_read", 32'(mem_read), 32'd1);
        check("ic1_mem_address", 32'(mem_address), 32'h05);
        wait_low(0, "ic1");
        check("ic1_readdata", ic_readdata, 32'hDEADBEEF);
        tick();
        check("ic1_stall_again", 32'(ic_busywait), 32'd1);
        ic_read = 0;
        tick();
        check("ic1_no_regrant", 32'(mem_read), 32'd0);
        check("ic1_dc_readdata", dc_readdata, 32'd0);

        // dcache writeback then read
        lat_fixed = 2;
        dc_write = 1; dc_address = 6'h2A; dc_writedata = 32'h12345678;
        tick();
        check("wb_mem_write", 32'(mem_write), 32'd1);
        check("wb_mem_read", 32'(mem_read), 32'd0);
        check("wb_mem_address", 32'(mem_address), 32'h2A);
        check("wb_mem_writedata", mem_writedata, 32'h12345678);
        dc_writedata = 32'hFFFF0000;
        wait_low(1, "wb");
        dc_write = 0; dc_read = 1; dc_address = 6'h0A;
        wait_low(1, "rd");
        check("rd_dc_readdata", dc_readdata, 32'hCAFE0A0A);
        check("wb_landed", mem_array[6'h2A], 32'h12345678);
        dc_read = 0;
        tick();

        // ties with round-robin: dcache first after reset, then alternation
        lat_fixed = -1;
        do_reset();
        grant_q.delete();
        ic_read = 1; ic_address = 6'h10; dc_read = 1; dc_address = 6'h20;
        wait_low(1, "tie1_dc");
        check("tie1_ic_stalled", 32'(ic_busywait), 32'd1);
        dc_address = 6'h21;
        wait_low(0, "tie2_ic");
        ic_read = 0;
        wait_low(1, "tie2_dc");
        dc_read = 0;
        tick(); tick();
        check("tie_grant_count", 32'(grant_q.size()), 32'd3);
        if (grant_q.size() == 3) begin
            check("tie_grant0", 32'(grant_q[0]), 32'h20);
            check("tie_grant1", 32'(grant_q[1]), 32'h10);
            check("tie_grant2", 32'(grant_q[2]), 32'h21);
        end

        // zero-wait memory, back-to-back icache reads
        lat_fixed = 0;
        for (int k = 0; k < 4; k++) begin
            ic_read = 1; ic_address = AW'(6'h30 + k);
            wait_low(0, "zw");
            check("zw_readdata", ic_readdata, mem_array[AW'(6'h30 + k)]);
        end
        ic_read = 0;
        tick(); tick();
        check("zw_busy_len", 32'(last_strobe_len), 32'd2);

        // dcache priority: ties always go to dcache even right after a dcache grant
        for (int r = 0; r < 3; r++) begin
            p_dc_read = 1; p_dc_address = AW'(6'h11 + r);
            wait_low(3, "p_lone");
            p_dc_read = 0;
            tick();
            p_ic_read = 1; p_ic_address = AW'(6'h30 + r);
            p_dc_read = 1; p_dc_address = AW'(6'h18 + r);
            tick();
            check("p_first_is_dc", 32'(p_mem_address), 32'(AW'(6'h18 + r)));
            wait_low(3, "p_dc");
            check("p_ic_stalled", 32'(p_ic_busywait), 32'd1);
            check("p_dc_readdata", p_dc_readdata, p_pattern(AW'(6'h18 + r)));
            p_dc_read = 0;
            wait_low(2, "p_ic");
            check("p_ic_readdata", p_ic_readdata, p_pattern(AW'(6'h30 + r)));
            p_ic_read = 0;
            tick();
        end

        // randomized requesters
        lat_fixed = -1;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (ic_read && !ic_busywait) begin
                ic_read = ($urandom_range(0, 1) == 1);
                ic_address = AW'($urandom);
            end else if (!ic_read) begin
                ic_read = ($urandom_range(0, 2) == 0);
                ic_address = AW'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                ic_address = AW'($urandom);
            end
            if ((dc_read || dc_write) && !dc_busywait) begin
                dc_read = 0; dc_write = 0;
            end else if (!(dc_read || dc_write) && $urandom_range(0, 2) == 0) begin
                a = AW'($urandom);
                dc_address = a;
                dc_writedata = $urandom;
                if ($urandom_range(0, 1) == 1) dc_write = 1; else dc_read = 1;
            end else if ($urandom_range(0, 7) == 0) begin
                dc_writedata = $urandom;
            end
            tick();
        end
        ic_read = 0; dc_read = 0; dc_write = 0;
        for (int c = 0; c < 12; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
